// File: rtl/wisc_pkg.sv
// Shared WISC-S25 types: opcodes, branch condition codes, the flag register
// layout and the opcode classes that decide which flags an instruction writes.
package wisc_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'h0,
      OP_SUB    = 4'h1,
      OP_XOR    = 4'h2,
      OP_RED    = 4'h3,
      OP_SLL    = 4'h4,
      OP_SRA    = 4'h5,
      OP_ROR    = 4'h6,
      OP_PADDSB = 4'h7,
      OP_LW     = 4'h8,
      OP_SW     = 4'h9,
      OP_LLB    = 4'hA,
      OP_LHB    = 4'hB,
      OP_B      = 4'hC,
      OP_BR     = 4'hD,
      OP_PCS    = 4'hE,
      OP_HLT    = 4'hF
   } opcode_t;

   typedef enum logic [2:0] {
      CC_NE  = 3'b000,
      CC_EQ  = 3'b001,
      CC_GT  = 3'b010,
      CC_LT  = 3'b011,
      CC_GE  = 3'b100,
      CC_LE  = 3'b101,
      CC_OV  = 3'b110,
      CC_UNC = 3'b111
   } ccc_t;

   typedef struct packed {
      logic z;
      logic v;
      logic n;
   } flags_t;

   typedef enum logic {
      ST_RUN,
      ST_HALTED
   } state_t;

   function automatic logic sets_all_flags(opcode_t op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   function automatic logic sets_z_only(opcode_t op);
      return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
   endfunction

endpackage

// File: rtl/ex_mem_flag_stage_if.sv
// EX-side inputs, handshake and EX/MEM register contents of the flag stage.
// The pipeline controller drives the master side; the stage is the slave.
interface ex_mem_flag_stage_if #(
   parameter int DW = 16,
   parameter int RW = 4
);
   logic          ex_valid;
   logic [3:0]    ex_opcode;
   logic [2:0]    ex_ccc;
   logic [DW-1:0] alu_result;
   logic          alu_pos_ovfl;
   logic          alu_neg_ovfl;
   logic [RW-1:0] ex_rd;
   logic          ex_reg_write;
   logic          ex_mem_read;
   logic          ex_mem_write;
   logic [DW-1:0] ex_store_data;
   logic          stall;
   logic          flush;

   logic          ex_ready;
   logic          branch_taken;
   logic          mem_valid;
   logic [DW-1:0] mem_result;
   logic [RW-1:0] mem_rd;
   logic          mem_reg_write;
   logic          mem_mem_read;
   logic          mem_mem_write;
   logic [DW-1:0] mem_store_data;
   logic          mem_halt;
   logic          flag_z;
   logic          flag_v;
   logic          flag_n;

   modport master (
      output ex_valid, ex_opcode, ex_ccc, alu_result, alu_pos_ovfl, alu_neg_ovfl,
             ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data,
             stall, flush,
      input  ex_ready, branch_taken, mem_valid, mem_result, mem_rd, mem_reg_write,
             mem_mem_read, mem_mem_write, mem_store_data, mem_halt,
             flag_z, flag_v, flag_n
   );

   modport slave (
      input  ex_valid, ex_opcode, ex_ccc, alu_result, alu_pos_ovfl, alu_neg_ovfl,
             ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data,
             stall, flush,
      output ex_ready, branch_taken, mem_valid, mem_result, mem_rd, mem_reg_write,
             mem_mem_read, mem_mem_write, mem_store_data, mem_halt,
             flag_z, flag_v, flag_n
   );
endinterface

// File: rtl/branch_cond_eval.sv
// Branch condition decode from a ccc field and a flag snapshot.
// Purely combinational so the ID-stage early-branch path can share it.
module branch_cond_eval
   import wisc_pkg::*;
(
   input  ccc_t   ccc,
   input  flags_t flags,
   output logic   cond
);

   always_comb begin
      cond = 1'b0;
      case (ccc)
         CC_NE:   cond = ~flags.z;
         CC_EQ:   cond = flags.z;
         CC_GT:   cond = ~flags.z & ~flags.n;
         CC_LT:   cond = flags.n;
         CC_GE:   cond = flags.z | (~flags.z & ~flags.n);
         CC_LE:   cond = flags.n | flags.z;
         CC_OV:   cond = flags.v;
         CC_UNC:  cond = 1'b1;
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with the architectural Z/V/N flag register,
// branch resolution for B/BR in EX, and the HLT stop state.
module ex_mem_flag_stage
   import wisc_pkg::*;
#(
   parameter int DW = 16,
   parameter int RW = 4
) (
   input logic               clk,
   input logic               rst,
   ex_mem_flag_stage_if.slave bus
);

   state_t        state_reg, state_next;
   flags_t        flags_reg, flags_next;
   opcode_t       opcode;
   logic          run;
   logic          adv;
   logic          is_branch;
   logic          cond;

   logic          mem_valid_reg;
   logic [DW-1:0] mem_result_reg;
   logic [RW-1:0] mem_rd_reg;
   logic          mem_reg_write_reg;
   logic          mem_mem_read_reg;
   logic          mem_mem_write_reg;
   logic [DW-1:0] mem_store_data_reg;
   logic          mem_halt_reg;

   assign opcode    = opcode_t'(bus.ex_opcode);
   assign run       = (state_reg == ST_RUN);
   assign adv       = bus.ex_valid & ~bus.stall & ~bus.flush & run;
   assign is_branch = (opcode == OP_B) || (opcode == OP_BR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   // HALTED is terminal: only reset brings the stage back.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RUN:    if (adv && (opcode == OP_HLT)) state_next = ST_HALTED;
         ST_HALTED: state_next = ST_HALTED;
         default:   state_next = ST_RUN;
      endcase
   end

   always_comb begin
      flags_next = flags_reg;
      if (adv) begin
         if (sets_all_flags(opcode)) begin
            flags_next.z = (bus.alu_result == '0);
            flags_next.v = bus.alu_pos_ovfl | bus.alu_neg_ovfl;
            flags_next.n = bus.alu_result[DW-1];
         end else if (sets_z_only(opcode)) begin
            flags_next.z = (bus.alu_result == '0);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_reg <= '0;
      end else begin
         flags_reg <= flags_next;
      end
   end

   branch_cond_eval u_branch_cond_eval (
      .ccc   (ccc_t'(bus.ex_ccc)),
      .flags (flags_reg),
      .cond  (cond)
   );

   // Without stall the register either takes the EX instruction or becomes a
   // fully cleared bubble; with stall it holds even if flush is raised.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_valid_reg      <= 1'b0;
         mem_result_reg     <= '0;
         mem_rd_reg         <= '0;
         mem_reg_write_reg  <= 1'b0;
         mem_mem_read_reg   <= 1'b0;
         mem_mem_write_reg  <= 1'b0;
         mem_store_data_reg <= '0;
         mem_halt_reg       <= 1'b0;
      end else if (!bus.stall) begin
         mem_valid_reg      <= adv;
         mem_result_reg     <= adv ? bus.alu_result : '0;
         mem_rd_reg         <= adv ? bus.ex_rd : '0;
         mem_reg_write_reg  <= adv & bus.ex_reg_write;
         mem_mem_read_reg   <= adv & bus.ex_mem_read;
         mem_mem_write_reg  <= adv & bus.ex_mem_write;
         mem_store_data_reg <= adv ? bus.ex_store_data : '0;
         mem_halt_reg       <= adv & (opcode == OP_HLT);
      end
   end

   assign bus.ex_ready       = ~bus.stall & run;
   assign bus.branch_taken   = bus.ex_valid & ~bus.flush & is_branch & cond & run;

   assign bus.mem_valid      = mem_valid_reg;
   assign bus.mem_result     = mem_result_reg;
   assign bus.mem_rd         = mem_rd_reg;
   assign bus.mem_reg_write  = mem_reg_write_reg;
   assign bus.mem_mem_read   = mem_mem_read_reg;
   assign bus.mem_mem_write  = mem_mem_write_reg;
   assign bus.mem_store_data = mem_store_data_reg;
   assign bus.mem_halt       = mem_halt_reg;
   assign bus.flag_z         = flags_reg.z;
   assign bus.flag_v         = flags_reg.v;
   assign bus.flag_n         = flags_reg.n;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed bench for ex_mem_flag_stage: a vector table for single-cycle
// behaviour plus hand sequences for stall, flush, HLT and reset.
module tb_ex_mem_flag_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   ex_mem_flag_stage_if #(.DW(16), .RW(4)) bus ();

   ex_mem_flag_stage #(.DW(16), .RW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        valid;
      logic [3:0]  op;
      logic [2:0]  ccc;
      logic [15:0] res;
      logic        pos;
      logic        neg;
      logic        flush;
      logic        bt;
      logic        mv;
      logic [15:0] mres;
      logic        z;
      logic        v;
      logic        n;
   } vec_t;

   vec_t vecs[29];

   function automatic vec_t mk(logic valid, logic [3:0] op, logic [2:0] ccc, logic [15:0] res,
                               logic pos, logic neg, logic flush, logic bt, logic mv,
                               logic [15:0] mres, logic z, logic v, logic n);
      vec_t t;
      t.valid = valid; t.op = op; t.ccc = ccc; t.res = res; t.pos = pos; t.neg = neg;
      t.flush = flush; t.bt = bt; t.mv = mv; t.mres = mres; t.z = z; t.v = v; t.n = n;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passed++;
   endtask

   task automatic drv(input logic valid, input logic [3:0] op, input logic [2:0] ccc,
                      input logic [15:0] res, input logic pos, input logic neg,
                      input logic [3:0] rd, input logic stall, input logic flush);
      bus.ex_valid      = valid;
      bus.ex_opcode     = op;
      bus.ex_ccc        = ccc;
      bus.alu_result    = res;
      bus.alu_pos_ovfl  = pos;
      bus.alu_neg_ovfl  = neg;
      bus.ex_rd         = rd;
      bus.ex_reg_write  = 1'b1;
      bus.ex_mem_read   = (op == 4'h8);
      bus.ex_mem_write  = (op == 4'h9);
      bus.ex_store_data = res ^ 16'hA5A5;
      bus.stall         = stall;
      bus.flush         = flush;
   endtask

   task automatic chk_regs(input string name, input logic mv, input logic [15:0] mres,
                           input logic halt, input logic z, input logic v, input logic n);
      check({name, ".mem_valid"},  bus.mem_valid,  mv);
      check({name, ".mem_result"}, bus.mem_result, mres);
      check({name, ".mem_halt"},   bus.mem_halt,   halt);
      check({name, ".flags"}, {bus.flag_z, bus.flag_v, bus.flag_n}, {z, v, n});
      $display("%s: mv=%0b res=%h halt=%0b zvn=%0b%0b%0b", name, bus.mem_valid,
               bus.mem_result, bus.mem_halt, bus.flag_z, bus.flag_v, bus.flag_n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // valid op ccc res pos neg flush | bt mv mres z v n
      vecs[0]  = mk(1, 4'h0, 3'd0, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 1, 0, 0);
      vecs[1]  = mk(1, 4'h0, 3'd0, 16'h8000, 1, 0, 0, 0, 1, 16'h8000, 0, 1, 1);
      vecs[2]  = mk(1, 4'h2, 3'd0, 16'h1234, 0, 0, 0, 0, 1, 16'h1234, 0, 1, 1);
      vecs[3]  = mk(1, 4'h1, 3'd0, 16'h0005, 0, 0, 0, 0, 1, 16'h0005, 0, 0, 0);
      vecs[4]  = mk(1, 4'hC, 3'd2, 16'h0000, 0, 0, 0, 1, 1, 16'h0000, 0, 0, 0);
      vecs[5]  = mk(1, 4'hC, 3'd3, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0);
      vecs[6]  = mk(1, 4'hC, 3'd7, 16'h0000, 0, 0, 0, 1, 1, 16'h0000, 0, 0, 0);
      vecs[7]  = mk(1, 4'hD, 3'd0, 16'h0000, 0, 0, 0, 1, 1, 16'h0000, 0, 0, 0);
      vecs[8]  = mk(1, 4'hC, 3'd1, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0);
      vecs[9]  = mk(1, 4'hC, 3'd6, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0);
      vecs[10] = mk(1, 4'hC, 3'd2, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0);
      vecs[11] = mk(1, 4'h0, 3'd0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0);
      vecs[12] = mk(0, 4'h0, 3'd0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
      vecs[13] = mk(1, 4'h1, 3'd0, 16'h7FFF, 0, 1, 0, 0, 1, 16'h7FFF, 0, 1, 0);
      vecs[14] = mk(1, 4'hC, 3'd6, 16'h0000, 0, 0, 0, 1, 1, 16'h0000, 0, 1, 0);
      vecs[15] = mk(1, 4'hC, 3'd5, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 0, 1, 0);
      vecs[16] = mk(1, 4'hC, 3'd4, 16'h0000, 0, 0, 0, 1, 1, 16'h0000, 0, 1, 0);
      vecs[17] = mk(1, 4'h0, 3'd0, 16'hFFFF, 0, 0, 0, 0, 1, 16'hFFFF, 0, 0, 1);
      vecs[18] = mk(1, 4'hC, 3'd3, 16'h0000, 0, 0, 0, 1, 1, 16'h0000, 0, 0, 1);
      vecs[19] = mk(1, 4'hC, 3'd2, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 1);
      vecs[20] = mk(1, 4'h4, 3'd0, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 1, 0, 1);
      vecs[21] = mk(1, 4'hC, 3'd1, 16'h0000, 0, 0, 0, 1, 1, 16'h0000, 1, 0, 1);
      vecs[22] = mk(1, 4'hA, 3'd0, 16'h00AB, 0, 0, 0, 0, 1, 16'h00AB, 1, 0, 1);
      vecs[23] = mk(1, 4'h8, 3'd0, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 1, 0, 1);
      vecs[24] = mk(1, 4'h6, 3'd0, 16'h0100, 0, 0, 0, 0, 1, 16'h0100, 0, 0, 1);
      vecs[25] = mk(1, 4'h7, 3'd0, 16'h0000, 1, 0, 0, 0, 1, 16'h0000, 0, 0, 1);
      vecs[26] = mk(1, 4'h9, 3'd0, 16'h8000, 0, 0, 0, 0, 1, 16'h8000, 0, 0, 1);
      vecs[27] = mk(1, 4'h5, 3'd0, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 1, 0, 1);
      vecs[28] = mk(1, 4'hC, 3'd5, 16'h0000, 0, 0, 0, 1, 1, 16'h0000, 1, 0, 1);

      // Reset state
      drv(0, 4'h0, 3'd0, 16'h0000, 0, 0, 4'h0, 0, 0);
      #2;
      chk_regs("reset", 0, 16'h0000, 0, 0, 0, 0);
      check("reset.mem_rd", bus.mem_rd, 0);
      check("reset.mem_reg_write", bus.mem_reg_write, 0);
      check("reset.mem_store_data", bus.mem_store_data, 0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      check("reset.ex_ready", bus.ex_ready, 1);
      @(posedge clk); #1;

      for (int i = 0; i < 29; i++) begin
         vec_t t;
         string nm;
         t  = vecs[i];
         nm = $sformatf("v%0d", i);
         drv(t.valid, t.op, t.ccc, t.res, t.pos, t.neg, i[3:0], 0, t.flush);
         #2;
         check({nm, ".ex_ready"}, bus.ex_ready, 1);
         check({nm, ".branch_taken"}, bus.branch_taken, t.bt);
         @(posedge clk); #1;
         chk_regs(nm, t.mv, t.mres, 0, t.z, t.v, t.n);
         check({nm, ".mem_rd"}, bus.mem_rd, t.mv ? i[3:0] : 4'h0);
         check({nm, ".mem_reg_write"}, bus.mem_reg_write, t.mv);
         check({nm, ".mem_mem_read"}, bus.mem_mem_read, t.mv & (t.op == 4'h8));
         check({nm, ".mem_mem_write"}, bus.mem_mem_write, t.mv & (t.op == 4'h9));
         check({nm, ".mem_store_data"}, bus.mem_store_data, t.mv ? (t.res ^ 16'hA5A5) : 16'h0000);
      end

      // Stall holds EX/MEM and flags; the instruction goes when stall drops
      drv(1, 4'h0, 3'd0, 16'h0042, 0, 0, 4'h5, 0, 0);
      @(posedge clk); #1;
      chk_regs("stall.pre", 1, 16'h0042, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         drv(1, 4'h1, 3'd0, 16'h0000, 0, 0, 4'h6, 1, 0);
         #2;
         check($sformatf("stall%0d.ex_ready", k), bus.ex_ready, 0);
         @(posedge clk); #1;
         chk_regs($sformatf("stall%0d", k), 1, 16'h0042, 0, 0, 0, 0);
         check($sformatf("stall%0d.mem_rd", k), bus.mem_rd, 4'h5);
      end
      drv(1, 4'h1, 3'd0, 16'h0000, 0, 0, 4'h6, 0, 0);
      #2;
      check("stall.release.ex_ready", bus.ex_ready, 1);
      @(posedge clk); #1;
      chk_regs("stall.release", 1, 16'h0000, 0, 1, 0, 0);
      check("stall.release.mem_rd", bus.mem_rd, 4'h6);

      // Stall wins over flush; flush alone bubbles
      drv(1, 4'h0, 3'd0, 16'h0077, 0, 0, 4'h7, 0, 0);
      @(posedge clk); #1;
      chk_regs("sf.pre", 1, 16'h0077, 0, 0, 0, 0);
      drv(1, 4'h0, 3'd0, 16'h0000, 0, 0, 4'h8, 1, 1);
      @(posedge clk); #1;
      chk_regs("sf.both", 1, 16'h0077, 0, 0, 0, 0);
      drv(1, 4'h0, 3'd0, 16'h0000, 0, 0, 4'h8, 0, 1);
      @(posedge clk); #1;
      chk_regs("sf.flush", 0, 16'h0000, 0, 0, 0, 0);

      // branch_taken is not gated by stall
      drv(1, 4'hC, 3'd7, 16'h0000, 0, 0, 4'h0, 1, 0);
      #2;
      check("bstall.branch_taken", bus.branch_taken, 1);
      check("bstall.ex_ready", bus.ex_ready, 0);
      @(posedge clk); #1;
      chk_regs("bstall", 0, 16'h0000, 0, 0, 0, 0);

      // HLT: stage stops accepting, flags frozen, branches suppressed
      drv(1, 4'h0, 3'd0, 16'h8000, 1, 0, 4'h1, 0, 0);
      @(posedge clk); #1;
      chk_regs("hlt.pre", 1, 16'h8000, 0, 0, 1, 1);
      drv(1, 4'hF, 3'd0, 16'h0000, 0, 0, 4'h0, 0, 0);
      #2;
      check("hlt.ex_ready_before", bus.ex_ready, 1);
      @(posedge clk); #1;
      chk_regs("hlt.adv", 1, 16'h0000, 1, 0, 1, 1);
      drv(1, 4'h0, 3'd0, 16'h0000, 0, 0, 4'h2, 0, 0);
      #2;
      check("hlt.ex_ready_after", bus.ex_ready, 0);
      @(posedge clk); #1;
      chk_regs("hlt.add_ignored", 0, 16'h0000, 0, 0, 1, 1);
      drv(1, 4'hC, 3'd7, 16'h0000, 0, 0, 4'h0, 0, 0);
      #2;
      check("hlt.branch_taken", bus.branch_taken, 0);
      check("hlt.ex_ready_still", bus.ex_ready, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk_regs("hlt.rst", 0, 16'h0000, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      drv(1, 4'h0, 3'd0, 16'h0000, 0, 0, 4'h3, 0, 0);
      #2;
      check("rst1.ex_ready", bus.ex_ready, 1);
      @(posedge clk); #1;
      chk_regs("rst1.add", 1, 16'h0000, 0, 1, 0, 0);

      // Reset in the middle of a stall that is holding a HLT in EX/MEM
      drv(1, 4'hF, 3'd0, 16'h0000, 0, 0, 4'h0, 0, 0);
      @(posedge clk); #1;
      chk_regs("hlt2.adv", 1, 16'h0000, 1, 1, 0, 0);
      drv(1, 4'h0, 3'd0, 16'h0000, 0, 0, 4'h4, 1, 0);
      @(posedge clk); #1;
      chk_regs("hlt2.stall", 1, 16'h0000, 1, 1, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk_regs("hlt2.rst", 0, 16'h0000, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      drv(1, 4'hC, 3'd7, 16'h0000, 0, 0, 4'h0, 0, 0);
      #2;
      check("rst2.ex_ready", bus.ex_ready, 1);
      check("rst2.branch_taken", bus.branch_taken, 1);
      @(posedge clk); #1;
      chk_regs("rst2.branch", 1, 16'h0000, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
